// File: rtl/vu_pwm_decoder.sv
// VU meter PWM receiver. For each of the left and right channels it
// measures the high time of the PWM waveform and turns it back into a
// 7-bit duty level. It produces one result per frame, plus a repeating
// timeout result while the line stays static.
module vu_pwm_decoder #(
   parameter int CLK_DIV      = 64,
   parameter int MAX_LEVEL    = 127,
   parameter int TIMEOUT_CLKS = 16384
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       l_VU_pwm_in,
   input  logic       r_VU_pwm_in,
   output logic [6:0] l_level,
   output logic [6:0] r_level,
   output logic       l_level_valid,
   output logic       r_level_valid,
   output logic       l_timeout,
   output logic       r_timeout
);

   localparam int DIV_SHIFT = $clog2(CLK_DIV);
   localparam int CNT_W     = $clog2(MAX_LEVEL * CLK_DIV + CLK_DIV) + 1;
   localparam int TMR_W     = $clog2(TIMEOUT_CLKS);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W:0]   HALF     = (CNT_W + 1)'(CLK_DIV / 2);
   localparam logic [CNT_W:0]   Q_MAX    = (CNT_W + 1)'(MAX_LEVEL);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
   localparam logic [6:0]       LVL_MAX  = 7'(MAX_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_t;

   logic [1:0] pin;
   logic [1:0] warm;
   logic       primed;

   assign pin = {r_VU_pwm_in, l_VU_pwm_in};

   // The sync flops come out of reset at 0. A pin that is already high
   // would then look like a fresh rise and report a truncated pulse.
   // Edge detection therefore waits until the whole chain holds real samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm <= 2'd0;
      end else if (warm != 2'd3) begin
         warm <= warm + 2'd1;
      end
   end

   assign primed = (warm == 2'd3);

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_ch
      logic             s1;
      logic             s2;
      logic             s3;
      logic             rise;
      logic             fall;
      state_t           state;
      logic [CNT_W-1:0] high_cnt;
      logic [TMR_W-1:0] timer;
      logic [CNT_W:0]   rounded;
      logic [CNT_W:0]   q;
      logic [6:0]       q_level;
      logic [6:0]       level;
      logic             level_valid;
      logic             timeout;

      // Three-flop synchroniser for the asynchronous PWM pin
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
         end else begin
            s1 <= pin[gi];
            s2 <= s1;
            s3 <= s2;
         end
      end

      assign rise = primed & s2 & ~s3;
      assign fall = primed & ~s2 & s3;

      // Round to the nearest step, then clamp to the 7-bit range
      assign rounded = {1'b0, high_cnt} + HALF;
      assign q       = rounded >> DIV_SHIFT;
      assign q_level = (q > Q_MAX) ? LVL_MAX : q[6:0];

      // Per-channel measurement FSM with high-time counter and static-line timer
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state       <= ST_IDLE;
            high_cnt    <= '0;
            timer       <= '0;
            level       <= 7'd0;
            level_valid <= 1'b0;
            timeout     <= 1'b0;
         end else if (!enable) begin
            // level deliberately holds its last value while disabled
            state       <= ST_IDLE;
            high_cnt    <= '0;
            timer       <= '0;
            level_valid <= 1'b0;
            timeout     <= 1'b0;
         end else begin
            level_valid <= 1'b0;

            if (rise) begin
               high_cnt <= CNT_W'(1);
            end else if (s2 && s3 && high_cnt != CNT_MAX) begin
               high_cnt <= high_cnt + CNT_W'(1);
            end

            // Any edge restarts the timer. Because edges take precedence,
            // a fall that lands on the expiry cycle suppresses the timeout.
            if (rise || fall) begin
               timer   <= '0;
               timeout <= 1'b0;
            end else if (timer == TMR_LAST) begin
               timer       <= '0;
               level       <= s2 ? LVL_MAX : 7'd0;
               level_valid <= 1'b1;
               timeout     <= 1'b1;
            end else begin
               timer <= timer + TMR_W'(1);
            end

            case (state)
               ST_IDLE: begin
                  // a fall here belongs to a pulse whose start was not seen
                  if (rise) begin
                     state <= ST_HIGH;
                  end
               end
               ST_HIGH: begin
                  if (fall) begin
                     state       <= ST_LOW;
                     level       <= q_level;
                     level_valid <= 1'b1;
                  end
               end
               ST_LOW: begin
                  if (rise) begin
                     state <= ST_HIGH;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign l_level       = g_ch[0].level;
   assign r_level       = g_ch[1].level;
   assign l_level_valid = g_ch[0].level_valid;
   assign r_level_valid = g_ch[1].level_valid;
   assign l_timeout     = g_ch[0].timeout;
   assign r_timeout     = g_ch[1].timeout;

endmodule

// File: tb/tb_vu_pwm_decoder.sv
// Bench for vu_pwm_decoder. It drives directed and random PWM frames on
// both channels and predicts every level_valid event (cycle, level and
// timeout flag) from the measurement rules using plain arithmetic.
module tb_vu_pwm_decoder;

   localparam int T_OUT   = 16384;
   localparam int DIV     = 64;
   localparam int MAXL    = 127;
   localparam int CNT_SAT = 16383;

   typedef struct {
      int unsigned t;
      logic [6:0]  lvl;
      logic        to;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       l_pin = 1'b0;
   logic       r_pin = 1'b0;
   logic [6:0] l_level;
   logic [6:0] r_level;
   logic       l_level_valid;
   logic       r_level_valid;
   logic       l_timeout;
   logic       r_timeout;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   ev_t         dq[2][$];
   ev_t         eq[2][$];
   int          dptr[2] = '{0, 0};
   int          last_lvl[2] = '{0, 0};

   vu_pwm_decoder dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .l_VU_pwm_in  (l_pin),
      .r_VU_pwm_in  (r_pin),
      .l_level      (l_level),
      .r_level      (r_level),
      .l_level_valid(l_level_valid),
      .r_level_valid(r_level_valid),
      .l_timeout    (l_timeout),
      .r_timeout    (r_timeout)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // record every strobe together with the edge number that produced it
   always @(negedge clk) begin
      if (l_level_valid === 1'b1) dq[0].push_back('{cyc, l_level, l_timeout});
      if (r_level_valid === 1'b1) dq[1].push_back('{cyc, r_level, r_timeout});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected events for one channel over a frame that starts at cycle t0,
   // with the pin high for h cycles out of tot. Edge k is the first edge that
   // samples the pin low (k = t0+h+1), and the result lands 2 edges later.
   task automatic predict(input int ch, input int unsigned t0, input int h, input int tot);
      int unsigned r_edge;
      int unsigned f_edge;
      int unsigned n_edge;
      int          hc;
      int          lvl;
      r_edge = t0 + 3;
      f_edge = r_edge + h;
      n_edge = r_edge + tot;
      for (int unsigned t = r_edge + T_OUT; t < f_edge; t += T_OUT)
         eq[ch].push_back('{t, 7'(MAXL), 1'b1});
      hc  = (h > CNT_SAT) ? CNT_SAT : h;
      lvl = (hc + DIV / 2) / DIV;
      if (lvl > MAXL) lvl = MAXL;
      eq[ch].push_back('{f_edge, 7'(lvl), 1'b0});
      last_lvl[ch] = lvl;
      for (int unsigned t = f_edge + T_OUT; t < n_edge; t += T_OUT) begin
         eq[ch].push_back('{t, 7'd0, 1'b1});
         last_lvl[ch] = 0;
      end
   endtask

   task automatic check_events(input int ch);
      string nm;
      ev_t   e;
      ev_t   d;
      nm = (ch == 0) ? "l" : "r";
      while (eq[ch].size() > 0 && eq[ch][0].t < cyc) begin
         e = eq[ch].pop_front();
         chk({nm, "_ev_present"}, (dptr[ch] < dq[ch].size()) ? 32'd1 : 32'd0, 32'd1);
         if (dptr[ch] < dq[ch].size()) begin
            d = dq[ch][dptr[ch]];
            dptr[ch]++;
            chk({nm, "_ev_time"}, d.t, e.t);
            chk({nm, "_ev_level"}, 32'(d.lvl), 32'(e.lvl));
            chk({nm, "_ev_timeout"}, 32'(d.to), 32'(e.to));
         end
      end
      chk({nm, "_no_extra_ev"},
          (dptr[ch] < dq[ch].size() && dq[ch][dptr[ch]].t < cyc) ? 32'd1 : 32'd0, 32'd0);
   endtask

   // both pins rise together; each falls after its own high time
   task automatic frame2(input int lh, input int rh, input int tot);
      int unsigned t0;
      t0 = cyc;
      predict(0, t0, lh, tot);
      predict(1, t0, rh, tot);
      for (int i = 0; i < tot; i++) begin
         l_pin = (i < lh);
         r_pin = (i < rh);
         @(negedge clk);
      end
      check_events(0);
      check_events(1);
      $display("frame lh=%0d rh=%0d tot=%0d l_level=%0d r_level=%0d checks=%0d",
               lh, rh, tot, l_level, r_level, checks);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_l_level"}, 32'(l_level), 32'd0);
      chk({tag, "_r_level"}, 32'(r_level), 32'd0);
      chk({tag, "_l_valid"}, 32'(l_level_valid), 32'd0);
      chk({tag, "_r_valid"}, 32'(r_level_valid), 32'd0);
      chk({tag, "_l_timeout"}, 32'(l_timeout), 32'd0);
      chk({tag, "_r_timeout"}, 32'(r_timeout), 32'd0);
   endtask

   initial begin
      int lh;
      int rh;
      int tot;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // duty 40 frames, plus saturation (q=128) and rounding on the right
      frame2(2560, 8191, 8192);
      frame2(2560, 2591, 8192);
      frame2(2592, 31, 2700);
      frame2(32, 640, 700);
      // independent duties 10 and 100
      frame2(640, 6400, 6500);
      // Left: timeout while high, then a fall and one low timeout.
      // Right: a fall on the exact expiry cycle, then repeating low timeouts.
      frame2(17000, 16384, 49200);

      for (int n = 0; n < 6; n++) begin
         lh  = int'($urandom_range(1, 1000));
         rh  = int'($urandom_range(1, 1000));
         tot = ((lh > rh) ? lh : rh) + int'($urandom_range(1, 400));
         frame2(lh, rh, tot);
      end

      // drop enable mid-pulse: nothing reported, level held, partial fall ignored
      l_pin = 1'b1;
      r_pin = 1'b1;
      repeat (300) @(negedge clk);
      enable = 1'b0;
      repeat (20) @(negedge clk);
      chk("en_l_level_held", 32'(l_level), 32'(last_lvl[0]));
      chk("en_r_level_held", 32'(r_level), 32'(last_lvl[1]));
      chk("en_l_timeout", 32'(l_timeout), 32'd0);
      enable = 1'b1;
      repeat (200) @(negedge clk);
      l_pin = 1'b0;
      r_pin = 1'b0;
      repeat (300) @(negedge clk);
      check_events(0);
      check_events(1);
      chk("en_l_level_after", 32'(l_level), 32'(last_lvl[0]));
      chk("en_r_level_after", 32'(r_level), 32'(last_lvl[1]));
      $display("enable_drop l_level=%0d r_level=%0d", l_level, r_level);
      frame2(700, 1300, 1500);

      // reset 500 cycles into a high pulse, released while the pin is still high
      l_pin = 1'b1;
      r_pin = 1'b1;
      repeat (500) @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("rst_mid");
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (300) @(negedge clk);
      l_pin = 1'b0;
      r_pin = 1'b0;
      repeat (300) @(negedge clk);
      check_events(0);
      check_events(1);
      chk("rst_l_level_after", 32'(l_level), 32'd0);
      chk("rst_r_level_after", 32'(r_level), 32'd0);
      $display("reset_mid_pulse l_level=%0d r_level=%0d", l_level, r_level);
      frame2(1280, 1920, 2000);

      repeat (5) @(negedge clk);
      check_events(0);
      check_events(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
